sensor_packet_arbiter: RTL and testbench

- Shares the single packet framer/serializer among the three sensor front-ends: temperature, humidity and motion.
- Each front-end presents a first-word-fall-through FIFO head (valid + 16-bit reading).
- The block picks one requester by fixed priority, with an aging override against starvation.
- It pops the winning FIFO, timestamps the sample and holds a packet request to the framer under a valid/ready handshake.

---
 rtl/iot_sensor_pkg.sv | 42 ++++
 rtl/sensor_age_tracker.sv | 45 ++++
 rtl/sensor_packet_arbiter.sv | 124 ++++++++++++
 tb/tb_sensor_packet_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iot_sensor_pkg.sv
// Shared types and constants for the IoT sensor subsystem.
// Provides the sensor identifiers, the arbiter FSM states, default widths and
// limits, the fixed arbitration order and a helper that picks the
// highest-priority member of a request mask.
package iot_sensor_pkg;

    localparam int unsigned SENSOR_DATA_WIDTH = 16;
    localparam int unsigned TIMESTAMP_WIDTH   = 16;
    localparam int unsigned NUM_SENSORS       = 3;
    localparam int unsigned ARB_AGE_WIDTH     = 4;
    localparam int unsigned ARB_AGE_LIMIT     = 12;

    typedef enum logic [1:0] {
        SENSOR_TEMPERATURE = 2'd0,
        SENSOR_HUMIDITY    = 2'd1,
        SENSOR_MOTION      = 2'd2
    } sensor_type_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_HOLD
    } arb_state_e;

    // Index 0 is the highest priority.
    localparam sensor_type_e PRIORITY_ORDER [NUM_SENSORS] = '{
        SENSOR_MOTION, SENSOR_TEMPERATURE, SENSOR_HUMIDITY
    };

    // Highest fixed-priority member of mask; result is don't-care when mask is 0.
    function automatic sensor_type_e pick_by_priority(input logic [NUM_SENSORS-1:0] mask);
        sensor_type_e win;
        win = PRIORITY_ORDER[0];
        // Walk from lowest to highest priority so the last hit wins.
        for (int i = int'(NUM_SENSORS) - 1; i >= 0; i--) begin
            if (mask[PRIORITY_ORDER[i]]) begin
                win = PRIORITY_ORDER[i];
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/sensor_age_tracker.sv
// Per-sensor starvation counter.
// Counts cycles a request waits without being popped, saturating at AGE_LIMIT.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_valid   - this sensor's FIFO is non-empty
//   req_pop     - this sensor is being popped this cycle
//   age         - current wait count
//   aged        - count has reached AGE_LIMIT
module sensor_age_tracker #(
    parameter int unsigned AGE_WIDTH = 4,
    parameter int unsigned AGE_LIMIT = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic                 req_pop,
    output logic [AGE_WIDTH-1:0] age,
    output logic                 aged
);

    localparam logic [AGE_WIDTH-1:0] LIMIT = AGE_WIDTH'(AGE_LIMIT);

    logic [AGE_WIDTH-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        if (!req_valid || req_pop) begin
            age_d = '0;
        end else if (age_q < LIMIT) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign age  = age_q;
    assign aged = (age_q == LIMIT);

endmodule

// File: rtl/sensor_packet_arbiter.sv
// Arbitrates the three sensor FIFOs onto the single packet framer.
// Picks a winner by fixed priority (motion > temperature > humidity) unless
// some waiting requester has aged out, pops it, timestamps the sample and
// holds the packet under a valid/ready handshake.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   enable         - permits new grants (an in-flight packet still completes)
//   timestamp      - free-running system time, captured at grant
//   req_valid      - per-sensor FIFO non-empty, indexed by sensor_type_e
//   req_data       - per-sensor FIFO head, sensor i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_pop        - one-hot FIFO pop, combinational, asserted in the grant cycle
//   pkt_valid      - packet request to framer
//   pkt_ready      - framer accepts the packet
//   pkt_sensor_id  - granted sensor
//   pkt_data       - captured reading
//   pkt_timestamp  - timestamp at grant
//   pkt_boosted    - packet was granted through the aging override
//   busy           - a packet is being held
module sensor_packet_arbiter
    import iot_sensor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SENSOR_DATA_WIDTH,
    parameter int unsigned TS_WIDTH   = TIMESTAMP_WIDTH,
    parameter int unsigned AGE_WIDTH  = ARB_AGE_WIDTH,
    parameter int unsigned AGE_LIMIT  = ARB_AGE_LIMIT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [TS_WIDTH-1:0]           timestamp,
    input  logic [NUM_SENSORS-1:0]        req_valid,
    input  logic [NUM_SENSORS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_SENSORS-1:0]        req_pop,
    output logic                          pkt_valid,
    input  logic                          pkt_ready,
    output sensor_type_e                  pkt_sensor_id,
    output logic [DATA_WIDTH-1:0]         pkt_data,
    output logic [TS_WIDTH-1:0]           pkt_timestamp,
    output logic                          pkt_boosted,
    output logic                          busy
);

    arb_state_e state_q, state_d;

    logic [AGE_WIDTH-1:0]   age [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] aged_flag;
    logic [NUM_SENSORS-1:0] aged_set;
    logic [NUM_SENSORS-1:0] pop;
    logic                   boost;
    logic                   grant;
    sensor_type_e           winner;

    for (genvar g = 0; g < int'(NUM_SENSORS); g++) begin : g_age
        sensor_age_tracker #(
            .AGE_WIDTH (AGE_WIDTH),
            .AGE_LIMIT (AGE_LIMIT)
        ) u_age (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_pop   (pop[g]),
            .age       (age[g]),
            .aged      (aged_flag[g])
        );
    end

    // A counter may still read AGE_LIMIT in the cycle its FIFO goes empty.
    assign aged_set = req_valid & aged_flag;

    always_comb begin
        boost  = |aged_set;
        winner = boost ? pick_by_priority(aged_set) : pick_by_priority(req_valid);
        // rst_n gating keeps pops quiet while reset is held.
        grant  = rst_n && (state_q == ARB_IDLE) && enable && (|req_valid);
        pop    = '0;
        if (grant) begin
            pop[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant) begin
                    state_d = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (pkt_ready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_sensor_id <= SENSOR_TEMPERATURE;
            pkt_data      <= '0;
            pkt_timestamp <= '0;
            pkt_boosted   <= 1'b0;
        end else if (grant) begin
            pkt_sensor_id <= winner;
            pkt_data      <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            pkt_timestamp <= timestamp;
            pkt_boosted   <= boost;
        end
    end

    assign req_pop   = pop;
    assign pkt_valid = (state_q == ARB_HOLD);
    assign busy      = (state_q == ARB_HOLD);

endmodule

// File: tb/tb_sensor_packet_arbiter.sv
module tb_sensor_packet_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        pkt_ready = 1'b0;
    logic [15:0] timestamp = '0;
    logic [2:0]  req_valid = '0;
    logic [47:0] req_data = '0;
    logic [2:0]  req_pop;
    logic        pkt_valid;
    logic [1:0]  pkt_sensor_id;
    logic [15:0] pkt_data;
    logic [15:0] pkt_timestamp;
    logic        pkt_boosted;
    logic        busy;
    logic [15:0] kk;

    sensor_packet_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .timestamp     (timestamp),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_pop       (req_pop),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .pkt_sensor_id (pkt_sensor_id),
        .pkt_data      (pkt_data),
        .pkt_timestamp (pkt_timestamp),
        .pkt_boosted   (pkt_boosted),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
        logic [15:0] ts;
        logic        boost;
    } pkt_t;

    typedef struct {
        logic        en;
        logic [2:0]  valid;
        logic [15:0] ts;
        logic [2:0]  exp_pop;
        logic        exp_pkt;
        logic [1:0]  exp_id;
        logic [15:0] exp_data;
    } vec_t;

    pkt_t sb[$];
    vec_t tbl[9];
    int   m_age[3];
    bit   m_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Motion, then temperature, then humidity.
    function automatic int pick(input logic [2:0] m);
        if (m[2]) return 2;
        if (m[0]) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_age[i] = 0;
        m_hold = 1'b0;
        sb.delete();
    endtask

    // Called at posedge+1 after inputs are set; returns at next posedge+1.
    task automatic cycle();
        logic [2:0] aged;
        logic [2:0] pop_e;
        logic       grant;
        logic       bst;
        int         w;
        pkt_t       e;
        pkt_t       f;
        #1;
        for (int i = 0; i < 3; i++) chk("age", 32'(dut.age[i]), m_age[i]);
        chk("pkt_valid", 32'(pkt_valid), 32'(m_hold));
        chk("busy", 32'(busy), 32'(m_hold));
        aged = '0;
        for (int i = 0; i < 3; i++) aged[i] = req_valid[i] && (m_age[i] == 12);
        grant = !m_hold && enable && (|req_valid);
        pop_e = '0;
        if (grant) begin
            bst = |aged;
            w = bst ? pick(aged) : pick(req_valid);
            pop_e[w] = 1'b1;
            e.id = 2'(w);
            e.data = req_data[w*16 +: 16];
            e.ts = timestamp;
            e.boost = bst;
            sb.push_back(e);
        end
        chk("req_pop", 32'(req_pop), 32'(pop_e));
        if (m_hold) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got packet held, expected none queued");
            end else begin
                f = sb[0];
                chk("pkt_id", 32'(pkt_sensor_id), 32'(f.id));
                chk("pkt_data", 32'(pkt_data), 32'(f.data));
                chk("pkt_ts", 32'(pkt_timestamp), 32'(f.ts));
                chk("pkt_boost", 32'(pkt_boosted), 32'(f.boost));
                if (pkt_ready) void'(sb.pop_front());
            end
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!req_valid[i] || pop_e[i]) m_age[i] = 0;
            else if (m_age[i] < 12) m_age[i] = m_age[i] + 1;
        end
        if (m_hold) m_hold = !pkt_ready;
        else m_hold = grant;
        #1;
        timestamp = timestamp + 16'd1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 3'b001, 16'h0050, 3'b001, 1'b1, 2'd0, 16'h1234};
        tbl[1] = '{1'b1, 3'b010, 16'h0061, 3'b010, 1'b1, 2'd1, 16'h5678};
        tbl[2] = '{1'b1, 3'b100, 16'h0072, 3'b100, 1'b1, 2'd2, 16'h9ABC};
        tbl[3] = '{1'b1, 3'b011, 16'h0083, 3'b001, 1'b1, 2'd0, 16'h1234};
        tbl[4] = '{1'b1, 3'b110, 16'h0094, 3'b100, 1'b1, 2'd2, 16'h9ABC};
        tbl[5] = '{1'b1, 3'b101, 16'h00A5, 3'b100, 1'b1, 2'd2, 16'h9ABC};
        tbl[6] = '{1'b1, 3'b111, 16'h00B6, 3'b100, 1'b1, 2'd2, 16'h9ABC};
        tbl[7] = '{1'b1, 3'b000, 16'h00C7, 3'b000, 1'b0, 2'd0, 16'h0000};
        tbl[8] = '{1'b0, 3'b111, 16'h00D8, 3'b000, 1'b0, 2'd0, 16'h0000};

        // Reset: pops must stay low even with requests pending.
        model_reset();
        req_valid = 3'b111;
        enable = 1'b1;
        #12;
        chk("rst_pop", 32'(req_pop), 32'd0);
        chk("rst_valid", 32'(pkt_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_id", 32'(pkt_sensor_id), 32'd0);
        chk("rst_data", 32'(pkt_data), 32'd0);
        chk("rst_ts", 32'(pkt_timestamp), 32'd0);
        chk("rst_boost", 32'(pkt_boosted), 32'd0);
        req_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) cycle();

        // Table vectors, each from IDLE with all ages clear.
        for (int v = 0; v < 9; v++) begin
            enable = tbl[v].en;
            req_valid = tbl[v].valid;
            req_data = {16'h9ABC, 16'h5678, 16'h1234};
            timestamp = tbl[v].ts;
            pkt_ready = 1'b1;
            #1;
            chk("tbl_pop", 32'(req_pop), 32'(tbl[v].exp_pop));
            cycle();
            if (tbl[v].exp_pkt) begin
                chk("tbl_valid", 32'(pkt_valid), 32'd1);
                chk("tbl_id", 32'(pkt_sensor_id), 32'(tbl[v].exp_id));
                chk("tbl_data", 32'(pkt_data), 32'(tbl[v].exp_data));
                chk("tbl_ts", 32'(pkt_timestamp), 32'(tbl[v].ts));
                chk("tbl_boost", 32'(pkt_boosted), 32'd0);
            end
            req_valid = 3'b000;
            cycle();
        end

        // All three requesting continuously: temperature then humidity age out.
        enable = 1'b1;
        pkt_ready = 1'b1;
        req_valid = 3'b111;
        for (int k = 0; k < 16; k++) begin
            kk = 16'(k);
            req_data = {16'h2000 | kk, 16'h1000 | kk, kk};
            #1;
            if (k == 12) chk("starve_temp_pop", 32'(req_pop), 32'b001);
            if (k == 14) chk("starve_hum_pop", 32'(req_pop), 32'b010);
            cycle();
            if (k == 14) begin
                chk("starve_hum_age", 32'(dut.age[1]), 32'd0);
                chk("starve_hum_boost", 32'(pkt_boosted), 32'd1);
                chk("starve_hum_id", 32'(pkt_sensor_id), 32'd1);
            end
        end
        req_valid = 3'b000;
        cycle();

        // enable low: ages saturate, then motion wins boosted.
        enable = 1'b0;
        req_valid = 3'b110;
        req_data = {16'hA0A0, 16'hB1B1, 16'hC2C2};
        repeat (14) cycle();
        chk("en0_age1", 32'(dut.age[1]), 32'd12);
        chk("en0_age2", 32'(dut.age[2]), 32'd12);
        enable = 1'b1;
        #1;
        chk("en1_pop", 32'(req_pop), 32'b100);
        cycle();
        chk("en1_boost", 32'(pkt_boosted), 32'd1);
        chk("en1_id", 32'(pkt_sensor_id), 32'd2);
        req_valid = 3'b000;
        cycle();

        // Framer stalls for 20 cycles while the FIFOs churn.
        req_valid = 3'b001;
        req_data = {16'h1111, 16'h2222, 16'h3333};
        cycle();
        pkt_ready = 1'b0;
        repeat (20) begin
            req_data = {$urandom(), 16'($urandom())};
            req_valid = 3'($urandom_range(0, 7));
            #1;
            chk("stall_pop", 32'(req_pop), 32'd0);
            cycle();
        end
        pkt_ready = 1'b1;
        cycle();
        chk("stall_idle", 32'(pkt_valid), 32'd0);
        req_valid = 3'b000;
        cycle();

        // enable drops during HOLD: packet completes, no further grants.
        req_valid = 3'b100;
        cycle();
        enable = 1'b0;
        cycle();
        repeat (3) begin
            #1;
            chk("endrop_pop", 32'(req_pop), 32'd0);
            cycle();
        end
        enable = 1'b1;
        cycle();
        req_valid = 3'b000;
        cycle();

        // Async reset in the middle of HOLD.
        req_valid = 3'b010;
        cycle();
        pkt_ready = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(pkt_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", 32'(pkt_data), 32'd0);
        chk("midrst_id", 32'(pkt_sensor_id), 32'd0);
        chk("midrst_pop", 32'(req_pop), 32'd0);
        model_reset();
        req_valid = 3'b000;
        pkt_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 3'b111;
        #1;
        chk("postrst_pop", 32'(req_pop), 32'b100);
        cycle();
        chk("postrst_boost", 32'(pkt_boosted), 32'd0);
        req_valid = 3'b000;
        cycle();
        cycle();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
